// File: rtl/dec_64b_pkg.sv
// dec_64b shared types and decode helpers.
// Thermometer mode is enabled by defining DEC_64B_THERMO_EN.
package dec_64b_pkg;

    localparam int DATA_W = 64;
    localparam int IDX_W  = 6;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [DATA_W-1:0] data_t;

    function automatic data_t onehot(idx_t idx);
        data_t r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    function automatic data_t thermo(idx_t idx);
        data_t r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = (i <= int'(idx));
        end
        return r;
    endfunction

endpackage

// File: rtl/dec_64b_stage.sv
// Generic valid/ready register slice for dec_64b.
// Full throughput: accepts a new beat in the cycle the held one leaves.
module dec_64b_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/dec_64b.sv
// 6-bit index to 64-bit one-hot decoder with valid/ready on both sides.
// DEC_64B_THERMO_EN adds in_mode_i selecting a thermometer code.
module dec_64b
    import dec_64b_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  in_data_i,
`ifdef DEC_64B_THERMO_EN
    input  logic              in_mode_i,
`endif
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

`ifdef DEC_64B_THERMO_EN
    localparam int PW = IDX_W + 1;

    logic [PW-1:0] in_pl;
    assign in_pl = {in_mode_i, in_data_i};

    function automatic data_t dec(logic [PW-1:0] p);
        return p[IDX_W] ? thermo(p[IDX_W-1:0]) : onehot(p[IDX_W-1:0]);
    endfunction
`else
    localparam int PW = IDX_W;

    logic [PW-1:0] in_pl;
    assign in_pl = in_data_i;

    function automatic data_t dec(logic [PW-1:0] p);
        return onehot(p);
    endfunction
`endif

    logic s1_ready;

    // Hold off upstream while reset is applied.
    assign in_ready_o = s1_ready && !rst_i;

    if (OUT_REG == 0) begin : g_lat1
        logic [PW-1:0] s1_pl;
        logic          s1_valid;

        dec_64b_stage #(.W(PW)) u_s1 (
            .clk       (clk_i),
            .rst       (rst_i),
            .in_data   (in_pl),
            .in_valid  (in_valid_i),
            .in_ready  (s1_ready),
            .out_data  (s1_pl),
            .out_valid (s1_valid),
            .out_ready (out_ready_i)
        );

        assign out_valid_o = s1_valid;
        assign out_data_o  = s1_valid ? dec(s1_pl) : '0;
    end else begin : g_lat2
        logic [PW-1:0] s1_pl;
        logic          s1_valid;
        logic          s2_ready;
        data_t         s2_data;
        logic          s2_valid;

        dec_64b_stage #(.W(PW)) u_s1 (
            .clk       (clk_i),
            .rst       (rst_i),
            .in_data   (in_pl),
            .in_valid  (in_valid_i),
            .in_ready  (s1_ready),
            .out_data  (s1_pl),
            .out_valid (s1_valid),
            .out_ready (s2_ready)
        );

        dec_64b_stage #(.W(DATA_W)) u_s2 (
            .clk       (clk_i),
            .rst       (rst_i),
            .in_data   (dec(s1_pl)),
            .in_valid  (s1_valid),
            .in_ready  (s2_ready),
            .out_data  (s2_data),
            .out_valid (s2_valid),
            .out_ready (out_ready_i)
        );

        assign out_valid_o = s2_valid;
        assign out_data_o  = s2_valid ? s2_data : '0;
    end

endmodule

// File: tb/tb_dec_64b.sv
// Randomized and directed bench for dec_64b, OUT_REG=0 and OUT_REG=1 side by side.
// Expected words come from a queue scoreboard fed by a shift-based model.
module tb_dec_64b;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv = 1'b0;
    logic [5:0]  idx = '0;
    logic        mode = 1'b0;
    logic        ordy = 1'b0;
    logic [1:0]  ir;
    logic [1:0]  ov;
    logic [63:0] od [2];

    exp_t sb [2][$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   lat_chk = 1'b0;

    always #5 clk = ~clk;

    dec_64b #(.OUT_REG(0)) dut0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (idx),
`ifdef DEC_64B_THERMO_EN
        .in_mode_i   (mode),
`endif
        .in_valid_i  (iv),
        .in_ready_o  (ir[0]),
        .out_data_o  (od[0]),
        .out_valid_o (ov[0]),
        .out_ready_i (ordy)
    );

    dec_64b #(.OUT_REG(1)) dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (idx),
`ifdef DEC_64B_THERMO_EN
        .in_mode_i   (mode),
`endif
        .in_valid_i  (iv),
        .in_ready_o  (ir[1]),
        .out_data_o  (od[1]),
        .out_valid_o (ov[1]),
        .out_ready_i (ordy)
    );

    function automatic logic [63:0] model(int i, logic m);
        logic [63:0] ones;
        ones = '1;
        if (m) return ones >> (63 - i);
        return 64'd1 << i;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [1:0]  hold;
        logic [63:0] hd [2];
        logic        was_rst;
        exp_t        e;
        #1;
        was_rst = rst;
        for (int d = 0; d < 2; d++) begin
            hold[d] = 1'b0;
            hd[d]   = '0;
            if (!rst) begin
                if (ov[d] && ordy) begin
                    chk($sformatf("spurious%0d", d), 64'(sb[d].size() > 0), 64'd1);
                    if (sb[d].size() > 0) begin
                        e = sb[d].pop_front();
                        chk($sformatf("data%0d", d), od[d], e.data);
                        if (lat_chk)
                            chk($sformatf("lat%0d", d), 64'(cyc - e.cyc), 64'(d + 1));
                    end
                end
                if (ov[d] && !ordy) begin
                    hold[d] = 1'b1;
                    hd[d]   = od[d];
                end
                if (iv && ir[d]) sb[d].push_back('{model(int'(idx), mode), cyc});
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (was_rst) begin
            sb[0].delete();
            sb[1].delete();
        end
        for (int d = 0; d < 2; d++) begin
            if (hold[d] && !was_rst) begin
                chk($sformatf("hold_v%0d", d), 64'(ov[d]), 64'd1);
                chk($sformatf("hold_d%0d", d), od[d], hd[d]);
            end
            if (!ov[d]) chk($sformatf("gate%0d", d), od[d], 64'd0);
        end
    endtask

`ifdef DEC_64B_THERMO_EN
    int          th_idx [4] = '{0, 7, 63, 7};
    logic        th_mode [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] th_exp [4] = '{64'h1, 64'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h80};
`endif

    initial begin
        @(negedge clk);
        // reset held for 3 cycles
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("rst_v%0d", d), 64'(ov[d]), 64'd0);
                chk($sformatf("rst_d%0d", d), od[d], 64'd0);
                chk($sformatf("rst_rdy%0d", d), 64'(ir[d]), 64'd0);
            end
        end
        rst = 1'b0;
        #1;
        chk("rdy_after_rst0", 64'(ir[0]), 64'd1);
        chk("rdy_after_rst1", 64'(ir[1]), 64'd1);

        // back-to-back sweep
        lat_chk = 1'b1;
        ordy    = 1'b1;
        iv      = 1'b1;
        for (int i = 0; i < 64; i++) begin
            idx = 6'(i);
            #1;
            chk("sweep_rdy1", 64'(ir[1]), 64'd1);
            tick();
        end
        iv = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("sweep_empty1", 64'(sb[1].size()), 64'd0);
        chk("sweep_empty0", 64'(sb[0].size()), 64'd0);
        lat_chk = 1'b0;

        // backpressure with capacity checks
        ordy = 1'b0;
        iv   = 1'b1;
        idx  = 6'd5;
        tick();
        idx = 6'd17;
        #1;
        chk("cap0_stall_rdy", 64'(ir[0]), 64'd0);
        tick();
        idx = 6'd63;
        #1;
        chk("cap1_stall_rdy", 64'(ir[1]), 64'd0);
        tick();
        tick();
        chk("bp_hold5", od[1], 64'd1 << 5);
        ordy = 1'b1;
        tick();
        iv = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("bp_empty1", 64'(sb[1].size()), 64'd0);

        // reset while stalled
        ordy = 1'b0;
        iv   = 1'b1;
        idx  = 6'd9;
        tick();
        iv = 1'b0;
        tick();
        tick();
        chk("stall_v1", 64'(ov[1]), 64'd1);
        chk("stall_d1", od[1], 64'd1 << 9);
        rst = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("mrst_v%0d", d), 64'(ov[d]), 64'd0);
            chk($sformatf("mrst_d%0d", d), od[d], 64'd0);
        end
        rst  = 1'b0;
        ordy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mrst_gone1", 64'(ov[1]), 64'd0);
            chk("mrst_gone0", 64'(ov[0]), 64'd0);
        end

        // single register stage latency
        iv  = 1'b1;
        idx = 6'd42;
        tick();
        iv = 1'b0;
        chk("lat1_v", 64'(ov[0]), 64'd1);
        chk("lat1_d", od[0], 64'd1 << 42);
        tick();
        tick();

`ifdef DEC_64B_THERMO_EN
        for (int k = 0; k < 4; k++) begin
            iv   = 1'b1;
            idx  = 6'(th_idx[k]);
            mode = th_mode[k];
            tick();
            iv = 1'b0;
            chk($sformatf("thermo%0d", k), od[0], th_exp[k]);
            tick();
            tick();
        end
        mode = 1'b0;
`endif

        // random traffic against the scoreboard
        for (int k = 0; k < 800; k++) begin
            iv   = 1'($urandom_range(0, 1));
            idx  = 6'($urandom);
`ifdef DEC_64B_THERMO_EN
            mode = 1'($urandom_range(0, 1));
`endif
            ordy = ($urandom_range(0, 3) != 0);
            tick();
        end
        iv   = 1'b0;
        ordy = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("rand_empty0", 64'(sb[0].size()), 64'd0);
        chk("rand_empty1", 64'(sb[1].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
